// File: rtl/uart_rx_core.sv
// uart_rx_core
//   8N1-style asynchronous serial receiver. It takes the already-synchronized
//   serial bit, detects the start bit, and samples every bit at mid-bit using
//   a clock-divider counter. Each good byte is delivered as a one-cycle valid
//   pulse, and bad frames are reported with one-cycle error pulses.
//
//   Optional feature: define UART_RX_PARITY_EN to add one even-parity bit
//   after the data bits. Without it, parity_err is tied to 0.
//
// Parameters
//   CLKDIV     clk cycles per serial bit (even, >= 4)
//   DATA_BITS  data bits per frame, LSB first (5..9)
//
// Ports
//   clk         receive-domain clock, posedge
//   reset       asynchronous active-high reset
//   rxd         synchronized serial line, idle high
//   rx_data     last good word, held until the next good frame
//   rx_valid    one-cycle pulse: rx_data was updated
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: parity mismatch
//   rx_busy     high whenever the FSM is not idle
module uart_rx_core #(
  parameter int CLKDIV    = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(CLKDIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [BW-1:0]        r_bit, w_bit_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_valid, w_valid_next;
  logic                 r_ferr, w_ferr_next;
  logic                 r_busy;
  logic                 w_sample;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr, w_perr_next;
  logic                 r_par_fail, w_par_fail_next;
`endif

  // Counter reaching zero marks the mid-bit sampling point.
  assign w_sample = (r_cnt == '0);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr_next     = 1'b0;
    w_par_fail_next = r_par_fail;
`endif
    case (r_state)
      S_IDLE: begin
        if (!rxd) begin
          w_state_next = S_START;
          w_cnt_next   = CNT_HALF;
        end
      end
      S_START: begin
        if (w_sample) begin
          if (rxd) begin
            // Line went back high before mid start bit: treat as a glitch.
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DATA;
            w_cnt_next   = CNT_FULL;
            w_bit_next   = '0;
`ifdef UART_RX_PARITY_EN
            w_par_fail_next = 1'b0;
`endif
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_DATA: begin
        if (w_sample) begin
          // Shift in at the MSB so the first (LSB) bit ends in bit 0.
          w_shift_next = {rxd, r_shift[DATA_BITS-1:1]};
          w_cnt_next   = CNT_FULL;
          if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit + BW'(1);
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_sample) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          w_par_fail_next = ^{r_shift, rxd};
          w_cnt_next      = CNT_FULL;
          w_state_next    = S_STOP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_sample) begin
          if (rxd) begin
            w_state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (r_par_fail) begin
              w_perr_next = 1'b1;
            end else begin
              w_data_next  = r_shift;
              w_valid_next = 1'b1;
            end
`else
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
`endif
          end else begin
            w_state_next = S_BREAK;
            w_ferr_next  = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_next = r_par_fail;
`endif
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      S_BREAK: begin
        // Hold here through a long low so a break reports one frame error.
        if (rxd) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr     <= 1'b0;
      r_par_fail <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr_next;
      r_busy  <= (w_state_next != S_IDLE);
`ifdef UART_RX_PARITY_EN
      r_perr     <= w_perr_next;
      r_par_fail <= w_par_fail_next;
`endif
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy   = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule
